// File: rtl/usb_hid_buttons.sv
// ---------------------------------------------------------------------------
// usb_hid_buttons
//   Front-panel button conditioner feeding the USB HID consumer-control
//   report stage. Each of the six raw active-low buttons is synchronised,
//   debounced and then stretched so that the host is guaranteed to see every
//   press in at least one acknowledged report, and the release afterwards.
//
//   Bit order: [5] Stop, [4] Prev, [3] Next, [2] Play/Pause,
//              [1] Vol Down, [0] Vol Up.
//
// Ports:
//   Clk      in   1  system clock, rising edge
//   nReset   in   1  asynchronous active-low reset
//   Buttons  in   6  raw button pins, active-low, asynchronous to Clk
//   IN_Ack   in   1  single-cycle pulse: host acknowledged an IN report
//   Status   out  6  stretched active-high report bits (registered)
//   Pressed  out  6  debounced active-high level, not stretched (registered)
// ---------------------------------------------------------------------------
module usb_hid_buttons #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ACKS_REQUIRED   = 2
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [5:0] Buttons,
    input  logic       IN_Ack,
    output logic [5:0] Status,
    output logic [5:0] Pressed
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]      ACK_REQ  = 2'(ACKS_REQUIRED);

    // REL: released; PU: pressed, unreported; PR: pressed, reported;
    // RU: released, unreported.
    typedef enum logic [1:0] {
        ST_REL = 2'd0,
        ST_PU  = 2'd1,
        ST_PR  = 2'd2,
        ST_RU  = 2'd3
    } state_e;

    logic [5:0]    r_sync1;
    logic [5:0]    r_sync2;
    logic [5:0]    r_deb;
    logic [5:0]    r_pressed;
    logic [5:0]    r_status;
    logic [CW-1:0] r_cnt [6];
    state_e        r_state [6];
    logic [1:0]    r_ack [6];

    logic [5:0]    w_deb_next;
    logic [CW-1:0] w_cnt_next [6];
    state_e        w_state_next [6];
    logic [1:0]    w_ack_next [6];
    logic [1:0]    w_ack_step [6];
    logic [5:0]    w_status_next;

    // Two-flop synchroniser per button; released (1) out of reset.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_sync1 <= 6'h3F;
            r_sync2 <= 6'h3F;
        end else begin
            r_sync1 <= Buttons;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state: count while the synchronised level differs from
    // the accepted one; any return to the accepted level restarts the count.
    always_comb begin
        w_deb_next = r_deb;
        for (int i = 0; i < 6; i++) begin
            w_cnt_next[i] = r_cnt[i];
            if (r_sync2[i] == r_deb[i]) begin
                w_cnt_next[i] = {CW{1'b0}};
            end else if (r_cnt[i] == CNT_LAST) begin
                w_deb_next[i] = r_sync2[i];
                w_cnt_next[i] = {CW{1'b0}};
            end else begin
                w_cnt_next[i] = r_cnt[i] + CW'(1);
            end
        end
    end

    // Debounce state; Pressed is loaded alongside the debounced level so it
    // changes on the same edge the new level is accepted.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_deb     <= 6'h3F;
            r_pressed <= 6'h00;
            for (int i = 0; i < 6; i++) begin
                r_cnt[i] <= {CW{1'b0}};
            end
        end else begin
            r_deb     <= w_deb_next;
            r_pressed <= ~w_deb_next;
            for (int i = 0; i < 6; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    // Stretch FSM next-state. PU and RU share one rule: count acks up to
    // ACK_REQ, then the button level alone picks the reported state (PR or
    // REL); before that it picks the unreported state (PU or RU). This makes
    // a re-press on the final ack land in PR with Status never dropping.
    always_comb begin
        w_status_next = 6'h00;
        for (int i = 0; i < 6; i++) begin
            w_state_next[i] = r_state[i];
            w_ack_next[i]   = r_ack[i];
            if (IN_Ack && (r_ack[i] != ACK_REQ)) begin
                w_ack_step[i] = r_ack[i] + 2'd1;
            end else begin
                w_ack_step[i] = r_ack[i];
            end
            case (r_state[i])
                ST_REL: begin
                    w_ack_next[i] = 2'd0;
                    if (r_pressed[i]) begin
                        w_state_next[i] = ST_PU;
                    end else begin
                        w_state_next[i] = ST_REL;
                    end
                end
                ST_PU, ST_RU: begin
                    w_ack_next[i] = w_ack_step[i];
                    if (w_ack_step[i] == ACK_REQ) begin
                        w_state_next[i] = r_pressed[i] ? ST_PR : ST_REL;
                    end else begin
                        w_state_next[i] = r_pressed[i] ? ST_PU : ST_RU;
                    end
                end
                ST_PR: begin
                    if (!r_pressed[i]) begin
                        w_state_next[i] = ST_REL;
                    end else begin
                        w_state_next[i] = ST_PR;
                    end
                end
                default: begin
                    w_state_next[i] = ST_REL;
                    w_ack_next[i]   = 2'd0;
                end
            endcase
            w_status_next[i] = (w_state_next[i] != ST_REL);
        end
    end

    // Stretch FSM state, ack counters and registered Status.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_status <= 6'h00;
            for (int i = 0; i < 6; i++) begin
                r_state[i] <= ST_REL;
                r_ack[i]   <= 2'd0;
            end
        end else begin
            r_status <= w_status_next;
            for (int i = 0; i < 6; i++) begin
                r_state[i] <= w_state_next[i];
                r_ack[i]   <= w_ack_next[i];
            end
        end
    end

    assign Status  = r_status;
    assign Pressed = r_pressed;

endmodule

// File: tb/tb_usb_hid_buttons.sv
// ---------------------------------------------------------------------------
// tb_usb_hid_buttons
//   Self-checking bench for usb_hid_buttons with DEBOUNCE_CYCLES=16 and
//   ACKS_REQUIRED=2. A pin change made just after a rising edge shows on
//   Pressed after 18 rising edges and on Status one edge later.
// ---------------------------------------------------------------------------
module tb_usb_hid_buttons;

    localparam int DB = 16;
    localparam int AR = 2;

    logic       Clk     = 1'b0;
    logic       nReset  = 1'b0;
    logic [5:0] Buttons = 6'h3F;
    logic       IN_Ack  = 1'b0;
    logic [5:0] Status;
    logic [5:0] Pressed;

    always #5 Clk = ~Clk;

    usb_hid_buttons #(
        .DEBOUNCE_CYCLES(DB),
        .ACKS_REQUIRED  (AR)
    ) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .Buttons(Buttons),
        .IN_Ack (IN_Ack),
        .Status (Status),
        .Pressed(Pressed)
    );

    typedef struct {
        logic [5:0] btn;
        logic       ack;
        int         cyc;
        logic [5:0] st;
        logic [5:0] pr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [5:0] st, input logic [5:0] pr);
        n_vec++;
        if (Status !== st || Pressed !== pr) begin
            n_err++;
            $display("FAIL %s: got Status=%h Pressed=%h, want Status=%h Pressed=%h",
                     name, Status, Pressed, st, pr);
        end
    endtask

    function automatic void add(input logic [5:0] btn, input logic ack, input int cyc,
                                input logic [5:0] st, input logic [5:0] pr);
        vec_t v;
        v.btn = btn; v.ack = ack; v.cyc = cyc; v.st = st; v.pr = pr;
        vecs.push_back(v);
    endfunction

    initial begin
        // Glitch on Vol Up shorter than the debounce window, then a real press.
        add(6'h3E, 1'b0, 10, 6'h00, 6'h00);
        add(6'h3F, 1'b0, 30, 6'h00, 6'h00);
        add(6'h3E, 1'b0, 17, 6'h00, 6'h00);
        add(6'h3E, 1'b0,  1, 6'h00, 6'h01);
        add(6'h3E, 1'b0,  1, 6'h01, 6'h01);
        add(6'h3E, 1'b0, 21, 6'h01, 6'h01);
        // Release with no acks: Status held until the second ack.
        add(6'h3F, 1'b0, 18, 6'h01, 6'h00);
        add(6'h3F, 1'b0, 40, 6'h01, 6'h00);
        add(6'h3F, 1'b1,  1, 6'h01, 6'h00);
        add(6'h3F, 1'b0,  3, 6'h01, 6'h00);
        add(6'h3F, 1'b1,  1, 6'h00, 6'h00);
        add(6'h3F, 1'b0,  2, 6'h00, 6'h00);
        // 20-cycle tap on Vol Down.
        add(6'h3D, 1'b0, 18, 6'h00, 6'h02);
        add(6'h3D, 1'b0,  2, 6'h02, 6'h02);
        add(6'h3F, 1'b0, 18, 6'h02, 6'h00);
        add(6'h3F, 1'b0, 40, 6'h02, 6'h00);
        add(6'h3F, 1'b1,  1, 6'h02, 6'h00);
        add(6'h3F, 1'b0,  1, 6'h02, 6'h00);
        add(6'h3F, 1'b1,  1, 6'h00, 6'h00);
        add(6'h3F, 1'b0,  1, 6'h00, 6'h00);
        // Play/Pause acknowledged while held, then released.
        add(6'h3B, 1'b0, 19, 6'h04, 6'h04);
        add(6'h3B, 1'b1,  1, 6'h04, 6'h04);
        add(6'h3B, 1'b0,  2, 6'h04, 6'h04);
        add(6'h3B, 1'b1,  1, 6'h04, 6'h04);
        add(6'h3B, 1'b0,  5, 6'h04, 6'h04);
        add(6'h3F, 1'b0, 18, 6'h04, 6'h00);
        add(6'h3F, 1'b0,  1, 6'h00, 6'h00);
        // Stop + Next together, 5-cycle bounce on Stop.
        add(6'h17, 1'b0,  2, 6'h00, 6'h00);
        add(6'h37, 1'b0,  5, 6'h00, 6'h00);
        add(6'h17, 1'b0, 10, 6'h00, 6'h00);
        add(6'h17, 1'b0,  1, 6'h00, 6'h08);
        add(6'h17, 1'b0,  1, 6'h08, 6'h08);
        add(6'h17, 1'b0,  6, 6'h08, 6'h28);
        add(6'h17, 1'b0,  1, 6'h28, 6'h28);
        // Release Next only: it waits for acks, Stop unaffected.
        add(6'h1F, 1'b0, 18, 6'h28, 6'h20);
        add(6'h1F, 1'b0,  5, 6'h28, 6'h20);
        add(6'h1F, 1'b1,  1, 6'h28, 6'h20);
        add(6'h1F, 1'b0,  1, 6'h28, 6'h20);
        add(6'h1F, 1'b1,  1, 6'h20, 6'h20);
        add(6'h1F, 1'b0,  2, 6'h20, 6'h20);
        add(6'h3F, 1'b0, 18, 6'h20, 6'h00);
        add(6'h3F, 1'b0,  1, 6'h00, 6'h00);

        // Reset state with all buttons released.
        step(3);
        check("in_reset", 6'h00, 6'h00);
        nReset = 1'b1;
        step(5);
        check("after_reset", 6'h00, 6'h00);

        foreach (vecs[i]) begin
            Buttons = vecs[i].btn;
            IN_Ack  = vecs[i].ack;
            step(vecs[i].cyc);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].pr);
        end
        IN_Ack = 1'b0;

        // Prev: RU with one ack, re-pressed on the cycle of the second ack.
        Buttons = 6'h2F;
        step(19);
        check("prev_press", 6'h10, 6'h10);
        Buttons = 6'h3F;
        step(19);
        check("prev_ru", 6'h10, 6'h00);
        IN_Ack = 1'b1;
        step(1);
        IN_Ack = 1'b0;
        check("prev_ack1", 6'h10, 6'h00);
        step(2);
        Buttons = 6'h2F;
        for (int k = 0; k < 18; k++) begin
            step(1);
            check($sformatf("prev_repress%0d", k), 6'h10, (k == 17) ? 6'h10 : 6'h00);
        end
        IN_Ack = 1'b1;
        step(1);
        IN_Ack = 1'b0;
        check("prev_ack2_press", 6'h10, 6'h10);
        step(3);
        check("prev_held", 6'h10, 6'h10);
        // Must be PR: release drops Status one cycle after Pressed with no acks.
        Buttons = 6'h3F;
        step(18);
        check("prev_rel_pressed", 6'h10, 6'h00);
        step(1);
        check("prev_rel_status", 6'h00, 6'h00);

        // Asynchronous reset while Status is asserted.
        Buttons = 6'h3E;
        step(19);
        check("pre_async_reset", 6'h01, 6'h01);
        #2;
        nReset = 1'b0;
        #1;
        check("async_reset", 6'h00, 6'h00);
        step(2);
        check("reset_held", 6'h00, 6'h00);
        nReset = 1'b1;
        step(17);
        check("post_reset_wait", 6'h00, 6'h00);
        step(1);
        check("post_reset_press", 6'h00, 6'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
